decode_flow_ctrl: RTL and testbench

// Pipeline controller for the decode stage of the OOO core. Sits between the fetch skid buffer and rename.

---
 rtl/decode_flow_ctrl.sv | 126 ++++++++++++
 tb/tb_decode_flow_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : decode_flow_ctrl
// Purpose  : Decode-stage holding register and valid/ready control between fetch and rename.
//            Provides free-register gating, illegal-opcode halt, flush drain and perf counters.
// Revision : 1.0
// ============================================================================
module decode_flow_ctrl #(
    parameter int N_PHYS       = 64,
    parameter int PREG_RESERVE = 0,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32,
    parameter int FREE_W       = $clog2(N_PHYS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_valid_i,
    output logic              fetch_ready_o,
    input  logic [31:0]       fetch_pc_i,
    input  logic [31:0]       fetch_inst_i,
    output logic [31:0]       dec_pc_o,
    output logic [31:0]       dec_inst_o,
    input  logic              dec_illegal_i,
    input  logic              dec_regwrite_i,
    input  logic [4:0]        dec_rd_i,
    output logic              ren_valid_o,
    input  logic              ren_ready_i,
    input  logic [FREE_W-1:0] free_cnt_i,
    input  logic              flush_i,
    output logic              halt_o,
    output logic [31:0]       illegal_pc_o,
    output logic [CNT_W-1:0]  inst_count_o,
    output logic [CNT_W-1:0]  stall_count_o
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t          state;
    logic            v;
    logic [FC_W-1:0] flush_cnt;

    logic needs_preg;
    logic can_go;
    logic fire;
    logic accept;

    assign needs_preg = dec_regwrite_i && (dec_rd_i != 5'd0);
    assign can_go     = !needs_preg || (free_cnt_i > FREE_W'(PREG_RESERVE));

    always_comb begin
        ren_valid_o   = 1'b0;
        fetch_ready_o = 1'b0;
        case (state)
            ST_RUN: begin
                // ren_valid_o is built without ren_ready_i so rename can depend on it
                ren_valid_o   = v && !dec_illegal_i && can_go;
                fetch_ready_o = !v || (ren_valid_o && ren_ready_i);
            end
            ST_FLUSH: fetch_ready_o = 1'b1;
            default: begin
                ren_valid_o   = 1'b0;
                fetch_ready_o = 1'b0;
            end
        endcase
    end

    assign fire   = ren_valid_o && ren_ready_i;
    assign accept = fetch_valid_i && fetch_ready_o;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_RUN;
            v             <= 1'b0;
            flush_cnt     <= '0;
            dec_pc_o      <= '0;
            dec_inst_o    <= '0;
            halt_o        <= 1'b0;
            illegal_pc_o  <= '0;
            inst_count_o  <= '0;
            stall_count_o <= '0;
        end else if (flush_i) begin
            state     <= ST_FLUSH;
            v         <= 1'b0;
            halt_o    <= 1'b0;
            flush_cnt <= FC_W'(FLUSH_CYCLES - 1);
        end else begin
            case (state)
                ST_RUN: begin
                    if (v && dec_illegal_i) begin
                        state        <= ST_HALT;
                        halt_o       <= 1'b1;
                        illegal_pc_o <= dec_pc_o;
                    end else begin
                        if (accept) begin
                            v          <= 1'b1;
                            dec_pc_o   <= fetch_pc_i;
                            dec_inst_o <= fetch_inst_i;
                        end else if (fire) begin
                            v <= 1'b0;
                        end
                        if (fire && (inst_count_o != {CNT_W{1'b1}}))
                            inst_count_o <= inst_count_o + CNT_W'(1);
                        if (v && !fire && (stall_count_o != {CNT_W{1'b1}}))
                            stall_count_o <= stall_count_o + CNT_W'(1);
                    end
                end
                ST_FLUSH: begin
                    // beats arriving here are stale and are dropped
                    if (flush_cnt == '0)
                        state <= ST_RUN;
                    else
                        flush_cnt <= flush_cnt - FC_W'(1);
                end
                default: state <= ST_HALT;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decode_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_flow_ctrl
// Purpose  : Directed scenarios plus randomized run against a queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_decode_flow_ctrl;

    localparam int N_PHYS       = 64;
    localparam int PREG_RESERVE = 0;
    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 32;
    localparam int FREE_W       = $clog2(N_PHYS + 1);

    localparam logic [31:0] ADDI_X1 = 32'h0010_0093;
    localparam logic [31:0] ADDI_X0 = 32'h0000_0013;
    localparam logic [31:0] SW_X1   = 32'h0011_2023;
    localparam logic [31:0] ADD_X5  = 32'h0020_82B3;
    localparam logic [31:0] ILLEGAL = 32'hFFFF_FFFF;

    logic              clk = 1'b0;
    logic              reset;
    logic              fetch_valid_i;
    logic              fetch_ready_o;
    logic [31:0]       fetch_pc_i;
    logic [31:0]       fetch_inst_i;
    logic [31:0]       dec_pc_o;
    logic [31:0]       dec_inst_o;
    logic              dec_illegal_i;
    logic              dec_regwrite_i;
    logic [4:0]        dec_rd_i;
    logic              ren_valid_o;
    logic              ren_ready_i;
    logic [FREE_W-1:0] free_cnt_i;
    logic              flush_i;
    logic              halt_o;
    logic [31:0]       illegal_pc_o;
    logic [CNT_W-1:0]  inst_count_o;
    logic [CNT_W-1:0]  stall_count_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Minimal stand-in for the combinational decoder on dec_inst_o
    function automatic logic is_illegal(input logic [31:0] inst);
        return inst[6:0] == 7'h7F;
    endfunction

    function automatic logic writes_rd(input logic [31:0] inst);
        case (inst[6:0])
            7'h13, 7'h33, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    assign dec_illegal_i  = is_illegal(dec_inst_o);
    assign dec_regwrite_i = writes_rd(dec_inst_o);
    assign dec_rd_i       = dec_inst_o[11:7];

    decode_flow_ctrl #(
        .N_PHYS(N_PHYS), .PREG_RESERVE(PREG_RESERVE),
        .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .fetch_valid_i(fetch_valid_i), .fetch_ready_o(fetch_ready_o),
        .fetch_pc_i(fetch_pc_i), .fetch_inst_i(fetch_inst_i),
        .dec_pc_o(dec_pc_o), .dec_inst_o(dec_inst_o),
        .dec_illegal_i(dec_illegal_i), .dec_regwrite_i(dec_regwrite_i), .dec_rd_i(dec_rd_i),
        .ren_valid_o(ren_valid_o), .ren_ready_i(ren_ready_i),
        .free_cnt_i(free_cnt_i), .flush_i(flush_i),
        .halt_o(halt_o), .illegal_pc_o(illegal_pc_o),
        .inst_count_o(inst_count_o), .stall_count_o(stall_count_o)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fetch_valid_i = 1'b0;
        fetch_pc_i    = '0;
        fetch_inst_i  = '0;
        ren_ready_i   = 1'b1;
        free_cnt_i    = FREE_W'(10);
        flush_i       = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        #1;
    endtask

    task automatic beat(input logic [31:0] pc, input logic [31:0] inst);
        fetch_valid_i = 1'b1;
        fetch_pc_i    = pc;
        fetch_inst_i  = inst;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (ren_valid_o !== 1'b0) begin failures++; $display("FAIL reset_ren_valid: got %b want 0", ren_valid_o); end
        checks++; if (fetch_ready_o !== 1'b1) begin failures++; $display("FAIL reset_fetch_ready: got %b want 1", fetch_ready_o); end
        checks++; if (halt_o !== 1'b0) begin failures++; $display("FAIL reset_halt: got %b want 0", halt_o); end
        checks++; if ({dec_pc_o, dec_inst_o, illegal_pc_o} !== 96'h0) begin failures++; $display("FAIL reset_regs: got %h/%h/%h want 0", dec_pc_o, dec_inst_o, illegal_pc_o); end
        checks++; if ({inst_count_o, stall_count_o} !== '0) begin failures++; $display("FAIL reset_counts: got %0d/%0d want 0/0", inst_count_o, stall_count_o); end
    endtask

    task automatic test_stream();
        do_reset();
        beat(32'h0, ADDI_X1);
        #1;
        checks++; if (ren_valid_o !== 1'b0) begin failures++; $display("FAIL stream_first_valid: got %b want 0", ren_valid_o); end
        cyc();
        for (int i = 1; i <= 4; i++) begin
            if (i < 4) beat(32'(4 * i), ADDI_X1); else fetch_valid_i = 1'b0;
            #1;
            checks++; if (ren_valid_o !== 1'b1 || fetch_ready_o !== 1'b1) begin failures++; $display("FAIL stream_beat%0d: got valid=%b ready=%b want 1/1", i, ren_valid_o, fetch_ready_o); end
            checks++; if (dec_pc_o !== 32'(4 * (i - 1))) begin failures++; $display("FAIL stream_pc%0d: got %h want %h", i, dec_pc_o, 32'(4 * (i - 1))); end
            cyc();
        end
        checks++; if (ren_valid_o !== 1'b0) begin failures++; $display("FAIL stream_drained: got %b want 0", ren_valid_o); end
        checks++; if (inst_count_o !== 32'd4 || stall_count_o !== 32'd0) begin failures++; $display("FAIL stream_counts: got %0d/%0d want 4/0", inst_count_o, stall_count_o); end
    endtask

    task automatic test_freelist_stall();
        do_reset();
        free_cnt_i = '0;
        beat(32'h100, ADDI_X1);
        cyc();
        fetch_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (ren_valid_o !== 1'b0 || fetch_ready_o !== 1'b0) begin failures++; $display("FAIL freelist_hold%0d: got valid=%b ready=%b want 0/0", i, ren_valid_o, fetch_ready_o); end
            cyc();
        end
        free_cnt_i = FREE_W'(1);
        #1;
        checks++; if (stall_count_o !== 32'd3) begin failures++; $display("FAIL freelist_stalls: got %0d want 3", stall_count_o); end
        checks++; if (ren_valid_o !== 1'b1 || fetch_ready_o !== 1'b1) begin failures++; $display("FAIL freelist_release: got valid=%b ready=%b want 1/1", ren_valid_o, fetch_ready_o); end
        cyc();
        checks++; if (inst_count_o !== 32'd1) begin failures++; $display("FAIL freelist_count: got %0d want 1", inst_count_o); end
    endtask

    task automatic test_no_dest();
        do_reset();
        free_cnt_i = '0;
        beat(32'h200, SW_X1);
        cyc();
        beat(32'h204, ADDI_X0);
        #1;
        checks++; if (ren_valid_o !== 1'b1) begin failures++; $display("FAIL nodest_sw: got %b want 1", ren_valid_o); end
        cyc();
        fetch_valid_i = 1'b0;
        #1;
        checks++; if (ren_valid_o !== 1'b1) begin failures++; $display("FAIL nodest_addi_x0: got %b want 1", ren_valid_o); end
        cyc();
        checks++; if (inst_count_o !== 32'd2 || stall_count_o !== 32'd0) begin failures++; $display("FAIL nodest_counts: got %0d/%0d want 2/0", inst_count_o, stall_count_o); end
    endtask

    task automatic test_backpressure();
        do_reset();
        ren_ready_i = 1'b0;
        beat(32'h300, ADDI_X1);
        cyc();
        beat(32'h304, ADD_X5);
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (ren_valid_o !== 1'b1 || fetch_ready_o !== 1'b0) begin failures++; $display("FAIL bp_hold%0d: got valid=%b ready=%b want 1/0", i, ren_valid_o, fetch_ready_o); end
            checks++; if (dec_inst_o !== ADDI_X1 || dec_pc_o !== 32'h300) begin failures++; $display("FAIL bp_stable%0d: got %h@%h want %h@300", i, dec_inst_o, dec_pc_o, ADDI_X1); end
            cyc();
        end
        fetch_valid_i = 1'b0;
        ren_ready_i   = 1'b1;
        cyc();
        cyc();
        checks++; if (ren_valid_o !== 1'b0) begin failures++; $display("FAIL bp_no_dup: got %b want 0", ren_valid_o); end
        checks++; if (inst_count_o !== 32'd1 || stall_count_o !== 32'd2) begin failures++; $display("FAIL bp_counts: got %0d/%0d want 1/2", inst_count_o, stall_count_o); end
    endtask

    task automatic test_illegal();
        do_reset();
        beat(32'h40, ILLEGAL);
        cyc();
        fetch_valid_i = 1'b0;
        #1;
        checks++; if (ren_valid_o !== 1'b0 || fetch_ready_o !== 1'b0) begin failures++; $display("FAIL illegal_offer: got valid=%b ready=%b want 0/0", ren_valid_o, fetch_ready_o); end
        cyc();
        checks++; if (halt_o !== 1'b1 || illegal_pc_o !== 32'h40) begin failures++; $display("FAIL illegal_halt: got halt=%b pc=%h want 1/40", halt_o, illegal_pc_o); end
        beat(32'h44, ADDI_X1);
        for (int i = 0; i < 12; i++) begin
            #1;
            checks++; if (ren_valid_o !== 1'b0 || fetch_ready_o !== 1'b0 || halt_o !== 1'b1) begin failures++; $display("FAIL illegal_stay%0d: got valid=%b ready=%b halt=%b want 0/0/1", i, ren_valid_o, fetch_ready_o, halt_o); end
            cyc();
        end
        checks++; if (stall_count_o !== 32'd0 || inst_count_o !== 32'd0) begin failures++; $display("FAIL illegal_counts: got %0d/%0d want 0/0", inst_count_o, stall_count_o); end
        fetch_valid_i = 1'b0;
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        #1;
        checks++; if (halt_o !== 1'b0 || fetch_ready_o !== 1'b1 || ren_valid_o !== 1'b0) begin failures++; $display("FAIL illegal_flush: got halt=%b ready=%b valid=%b want 0/1/0", halt_o, fetch_ready_o, ren_valid_o); end
    endtask

    task automatic test_flush();
        do_reset();
        ren_ready_i = 1'b0;
        beat(32'h500, ADDI_X1);
        cyc();
        fetch_valid_i = 1'b0;
        flush_i       = 1'b1;
        ren_ready_i   = 1'b1;
        cyc();
        flush_i = 1'b0;
        for (int i = 0; i < FLUSH_CYCLES; i++) begin
            beat(32'h600 + 32'(4 * i), ADD_X5);
            #1;
            checks++; if (fetch_ready_o !== 1'b1 || ren_valid_o !== 1'b0) begin failures++; $display("FAIL flush_drain%0d: got ready=%b valid=%b want 1/0", i, fetch_ready_o, ren_valid_o); end
            cyc();
        end
        checks++; if (inst_count_o !== 32'd0 || stall_count_o !== 32'd0) begin failures++; $display("FAIL flush_counts: got %0d/%0d want 0/0", inst_count_o, stall_count_o); end
        beat(32'h700, ADDI_X1);
        cyc();
        fetch_valid_i = 1'b0;
        #1;
        checks++; if (ren_valid_o !== 1'b1 || dec_pc_o !== 32'h700) begin failures++; $display("FAIL flush_resume: got valid=%b pc=%h want 1/700", ren_valid_o, dec_pc_o); end
        cyc();
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        reset   = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        checks++; if (inst_count_o !== 32'd0 || dec_pc_o !== 32'd0 || halt_o !== 1'b0) begin failures++; $display("FAIL flush_reset: got cnt=%0d pc=%h halt=%b want 0/0/0", inst_count_o, dec_pc_o, halt_o); end
        beat(32'h800, ADDI_X0);
        cyc();
        fetch_valid_i = 1'b0;
        #1;
        checks++; if (ren_valid_o !== 1'b1 || dec_pc_o !== 32'h800) begin failures++; $display("FAIL flush_reset_run: got valid=%b pc=%h want 1/800", ren_valid_o, dec_pc_o); end
        cyc();
    endtask

    task automatic test_random();
        logic [63:0] held[$];
        int          flush_left;
        bit          halted;
        logic [31:0] m_pc, m_inst, m_ill, m_icnt, m_scnt, hinst, pick;
        logic        occ, exp_rv, exp_fr, exp_fire;
        int          r;

        do_reset();
        held.delete();
        flush_left = 0; halted = 0;
        m_pc = '0; m_inst = '0; m_ill = '0; m_icnt = '0; m_scnt = '0;

        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 15));
            pick = (r == 0) ? ILLEGAL : (r < 5) ? ADDI_X1 : (r < 8) ? ADDI_X0 : (r < 11) ? SW_X1 : ADD_X5;
            reset         = ($urandom_range(0, 299) == 0);
            flush_i       = ($urandom_range(0, 39) == 0);
            fetch_valid_i = $urandom_range(0, 1) == 1;
            fetch_pc_i    = $urandom;
            fetch_inst_i  = pick;
            ren_ready_i   = $urandom_range(0, 3) != 0;
            free_cnt_i    = FREE_W'($urandom_range(0, 3));
            #1;

            occ    = held.size() > 0;
            hinst  = occ ? held[0][31:0] : 32'h0;
            exp_rv = !halted && flush_left == 0 && occ && !is_illegal(hinst) &&
                     (!(writes_rd(hinst) && hinst[11:7] != 5'd0) || int'(free_cnt_i) > PREG_RESERVE);
            exp_fire = exp_rv && ren_ready_i;
            exp_fr = (flush_left > 0) ? 1'b1 : halted ? 1'b0 : (!occ || exp_fire);

            checks++; if (ren_valid_o !== exp_rv) begin failures++; $display("FAIL rand_ren_valid@%0d: got %b want %b", n, ren_valid_o, exp_rv); end
            checks++; if (fetch_ready_o !== exp_fr) begin failures++; $display("FAIL rand_fetch_ready@%0d: got %b want %b", n, fetch_ready_o, exp_fr); end
            checks++; if (halt_o !== halted || illegal_pc_o !== m_ill) begin failures++; $display("FAIL rand_halt@%0d: got %b/%h want %b/%h", n, halt_o, illegal_pc_o, halted, m_ill); end
            checks++; if (dec_pc_o !== m_pc || dec_inst_o !== m_inst) begin failures++; $display("FAIL rand_dec@%0d: got %h/%h want %h/%h", n, dec_pc_o, dec_inst_o, m_pc, m_inst); end
            checks++; if (inst_count_o !== m_icnt || stall_count_o !== m_scnt) begin failures++; $display("FAIL rand_counts@%0d: got %0d/%0d want %0d/%0d", n, inst_count_o, stall_count_o, m_icnt, m_scnt); end

            if (reset) begin
                held.delete();
                flush_left = 0; halted = 0;
                m_pc = '0; m_inst = '0; m_ill = '0; m_icnt = '0; m_scnt = '0;
            end else if (flush_i) begin
                held.delete();
                halted = 0;
                flush_left = FLUSH_CYCLES;
            end else if (flush_left > 0) begin
                flush_left--;
            end else if (!halted) begin
                if (occ && is_illegal(hinst)) begin
                    halted = 1;
                    m_ill  = held[0][63:32];
                end else begin
                    if (exp_fire) begin
                        if (m_icnt != 32'hFFFF_FFFF) m_icnt++;
                        void'(held.pop_front());
                    end else if (occ) begin
                        if (m_scnt != 32'hFFFF_FFFF) m_scnt++;
                    end
                    if (fetch_valid_i && exp_fr) begin
                        held.push_back({fetch_pc_i, fetch_inst_i});
                        m_pc   = fetch_pc_i;
                        m_inst = fetch_inst_i;
                    end
                end
            end
            cyc();
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_stream();
        test_freelist_stall();
        test_no_dest();
        test_backpressure();
        test_illegal();
        test_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
